// File: rtl/lut_check_pkg.sv
// Shared types for the LUT coefficient checker: scan FSM states and the
// first-mismatch record, plus the address-width helper used by every block.
package lut_check_pkg;

   localparam int FE_ADDR_W = 16;
   localparam int FE_COEF_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Fields are sized for the largest supported configuration; users slice.
   typedef struct packed {
      logic [FE_ADDR_W-1:0] bank;
      logic [FE_ADDR_W-1:0] lut;
      logic [FE_ADDR_W-1:0] idx;
      logic [FE_COEF_W-1:0] got;
      logic [FE_COEF_W-1:0] exp;
   } first_err_t;

   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lut_coef_checker_if.sv
// Coefficient read bus shared by the checker (master) and the two coefficient
// sources (slave): one address/strobe out, loaded and golden words back.
interface lut_coef_checker_if
   import lut_check_pkg::*;
#(
   parameter int N_BANKS  = 2,
   parameter int N_LUTS   = 8,
   parameter int LUT_SIZE = 8,
   parameter int COEF_W   = 24
);
   localparam int BANK_W = addr_w(N_BANKS);
   localparam int LUT_W  = addr_w(N_LUTS);
   localparam int IDX_W  = addr_w(LUT_SIZE);

   logic                     rd_en;
   logic [BANK_W-1:0]        rd_bank;
   logic [LUT_W-1:0]         rd_lut;
   logic [IDX_W-1:0]         rd_idx;
   logic signed [COEF_W-1:0] dut_coef;
   logic signed [COEF_W-1:0] gold_coef;

   modport master (
      output rd_en, rd_bank, rd_lut, rd_idx,
      input  dut_coef, gold_coef
   );

   modport slave (
      input  rd_en, rd_bank, rd_lut, rd_idx,
      output dut_coef, gold_coef
   );

endinterface

// File: rtl/lut_scan_addr.sv
// Nested bank/lut/idx address counter: idx runs fastest, wraps to (0,0,0)
// after the last address so a following scan needs no explicit clear.
module lut_scan_addr
   import lut_check_pkg::*;
#(
   parameter int N_BANKS  = 2,
   parameter int N_LUTS   = 8,
   parameter int LUT_SIZE = 8,
   localparam int BANK_W  = addr_w(N_BANKS),
   localparam int LUT_W   = addr_w(N_LUTS),
   localparam int IDX_W   = addr_w(LUT_SIZE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              en_i,
   output logic [BANK_W-1:0] bank_o,
   output logic [LUT_W-1:0]  lut_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              first_o,
   output logic              last_o
);

   logic [BANK_W-1:0] bank_q, bank_d;
   logic [LUT_W-1:0]  lut_q, lut_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              bank_max, lut_max, idx_max;

   assign bank_max = (bank_q == BANK_W'(N_BANKS - 1));
   assign lut_max  = (lut_q == LUT_W'(N_LUTS - 1));
   assign idx_max  = (idx_q == IDX_W'(LUT_SIZE - 1));

   always_comb begin
      bank_d = bank_q;
      lut_d  = lut_q;
      idx_d  = idx_q;
      if (clr_i) begin
         bank_d = '0;
         lut_d  = '0;
         idx_d  = '0;
      end else if (en_i) begin
         if (!idx_max) begin
            idx_d = idx_q + IDX_W'(1);
         end else begin
            idx_d = '0;
            if (!lut_max) begin
               lut_d = lut_q + LUT_W'(1);
            end else begin
               lut_d  = '0;
               bank_d = bank_max ? '0 : bank_q + BANK_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bank_q <= '0;
         lut_q  <= '0;
         idx_q  <= '0;
      end else begin
         bank_q <= bank_d;
         lut_q  <= lut_d;
         idx_q  <= idx_d;
      end
   end

   assign bank_o  = bank_q;
   assign lut_o   = lut_q;
   assign idx_o   = idx_q;
   assign first_o = (bank_q == '0) && (lut_q == '0) && (idx_q == '0);
   assign last_o  = bank_max && lut_max && idx_max;

endmodule

// File: rtl/lut_coef_checker.sv
// Scans every coefficient address, compares loaded against golden words one
// cycle after each read, and reports mismatch count plus the first failure.
module lut_coef_checker
   import lut_check_pkg::*;
#(
   parameter int N_BANKS  = 2,
   parameter int N_LUTS   = 8,
   parameter int LUT_SIZE = 8,
   parameter int COEF_W   = 24,
   parameter int CNT_W    = 16,
   localparam int BANK_W  = addr_w(N_BANKS),
   localparam int LUT_W   = addr_w(N_LUTS),
   localparam int IDX_W   = addr_w(LUT_SIZE)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     continuous,
   input  logic                     abort,
   lut_coef_checker_if.master       rd_bus,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [CNT_W-1:0]         err_cnt,
   output logic                     first_err_valid,
   output logic [BANK_W-1:0]        first_err_bank,
   output logic [LUT_W-1:0]         first_err_lut,
   output logic [IDX_W-1:0]         first_err_idx,
   output logic signed [COEF_W-1:0] first_err_got,
   output logic signed [COEF_W-1:0] first_err_exp
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_e            state_q, state_d;
   logic              start_acc, rd_en, scan_clr;
   logic [BANK_W-1:0] cnt_bank;
   logic [LUT_W-1:0]  cnt_lut;
   logic [IDX_W-1:0]  cnt_idx;
   logic              cnt_first, cnt_last;

   logic              vld_p1, last_p1;
   logic [BANK_W-1:0] bank_p1;
   logic [LUT_W-1:0]  lut_p1;
   logic [IDX_W-1:0]  idx_p1;

   logic              cmp_vld, mism;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic              fev_q, fev_d;
   first_err_t        fe_q, fe_d;
   logic              done_q, done_d, pass_q, pass_d;
   logic              unused_fe_hi;

   assign start_acc = (state_q == ST_IDLE) && start && !abort;

   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      busy    = 1'b0;
      unique case (state_q)
         ST_IDLE:  if (start_acc) state_d = ST_SCAN;
         ST_SCAN: begin
            rd_en = 1'b1;
            busy  = 1'b1;
            if (cnt_last) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy    = 1'b1;
            state_d = continuous ? ST_SCAN : ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
   end

   lut_scan_addr #(
      .N_BANKS (N_BANKS),
      .N_LUTS  (N_LUTS),
      .LUT_SIZE(LUT_SIZE)
   ) u_addr (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (start_acc | abort),
      .en_i   (rd_en),
      .bank_o (cnt_bank),
      .lut_o  (cnt_lut),
      .idx_o  (cnt_idx),
      .first_o(cnt_first),
      .last_o (cnt_last)
   );

   assign rd_bus.rd_en   = rd_en;
   assign rd_bus.rd_bank = cnt_bank;
   assign rd_bus.rd_lut  = cnt_lut;
   assign rd_bus.rd_idx  = cnt_idx;

   // p0 -> p1: address issued, coefficients return on the next cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else begin
         vld_p1  <= rd_en & ~abort;
         last_p1 <= cnt_last;
      end
      bank_p1 <= cnt_bank;
      lut_p1  <= cnt_lut;
      idx_p1  <= cnt_idx;
   end

   // p1 compare; a restart clears in its first read cycle, when nothing is in flight
   assign cmp_vld  = vld_p1 & ~abort;
   assign mism     = cmp_vld && (rd_bus.dut_coef != rd_bus.gold_coef);
   assign scan_clr = start_acc | (rd_en & cnt_first);

   always_comb begin
      err_cnt_d = err_cnt_q;
      fev_d     = fev_q;
      fe_d      = fe_q;
      done_d    = 1'b0;
      pass_d    = pass_q;
      if (scan_clr) begin
         err_cnt_d = '0;
         fev_d     = 1'b0;
      end else if (mism) begin
         err_cnt_d = sat_inc(err_cnt_q);
         if (!fev_q) begin
            fev_d     = 1'b1;
            fe_d.bank = FE_ADDR_W'(bank_p1);
            fe_d.lut  = FE_ADDR_W'(lut_p1);
            fe_d.idx  = FE_ADDR_W'(idx_p1);
            fe_d.got  = FE_COEF_W'(rd_bus.dut_coef);
            fe_d.exp  = FE_COEF_W'(rd_bus.gold_coef);
         end
      end
      if (cmp_vld && last_p1) begin
         done_d = 1'b1;
         pass_d = (err_cnt_q == '0) && !mism;
      end
   end

   // p1 -> p2: result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         err_cnt_q <= '0;
         fev_q     <= 1'b0;
         fe_q      <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         err_cnt_q <= err_cnt_d;
         fev_q     <= fev_d;
         fe_q      <= fe_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
      end
   end

   assign done            = done_q;
   assign pass            = pass_q;
   assign err_cnt         = err_cnt_q;
   assign first_err_valid = fev_q;
   assign first_err_bank  = fe_q.bank[BANK_W-1:0];
   assign first_err_lut   = fe_q.lut[LUT_W-1:0];
   assign first_err_idx   = fe_q.idx[IDX_W-1:0];
   assign first_err_got   = signed'(fe_q.got[COEF_W-1:0]);
   assign first_err_exp   = signed'(fe_q.exp[COEF_W-1:0]);
   assign unused_fe_hi    = ^fe_q;

endmodule

// File: tb/tb_lut_coef_checker.sv
// Bench for lut_coef_checker: table-driven scans, randomized scans against a
// whole-memory reference, and hand sequences for continuous/abort/reset.
module tb_lut_coef_checker;

   localparam int NB = 2, NL = 8, LS = 8, CW = 24, T = NB * NL * LS;

   logic clk = 1'b0;
   logic rst, start, continuous, abort;
   always #5 clk = ~clk;

   lut_coef_checker_if #(.N_BANKS(NB), .N_LUTS(NL), .LUT_SIZE(LS), .COEF_W(CW)) bus ();
   lut_coef_checker_if #(.N_BANKS(NB), .N_LUTS(NL), .LUT_SIZE(LS), .COEF_W(CW)) bus2 ();

   logic                 busy, done, pass, fev;
   logic [15:0]          err_cnt;
   logic [0:0]           feb;
   logic [2:0]           fel, fei;
   logic signed [CW-1:0] fegot, feexp;

   logic                 busy2, done2, pass2, fev2;
   logic [1:0]           err_cnt2;
   logic [0:0]           feb2;
   logic [2:0]           fel2, fei2;
   logic signed [CW-1:0] fegot2, feexp2;

   lut_coef_checker #(.N_BANKS(NB), .N_LUTS(NL), .LUT_SIZE(LS), .COEF_W(CW), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
      .rd_bus(bus), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .first_err_valid(fev), .first_err_bank(feb), .first_err_lut(fel), .first_err_idx(fei),
      .first_err_got(fegot), .first_err_exp(feexp)
   );

   lut_coef_checker #(.N_BANKS(NB), .N_LUTS(NL), .LUT_SIZE(LS), .COEF_W(CW), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
      .rd_bus(bus2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
      .first_err_valid(fev2), .first_err_bank(feb2), .first_err_lut(fel2), .first_err_idx(fei2),
      .first_err_got(fegot2), .first_err_exp(feexp2)
   );

   logic signed [CW-1:0] gold_mem [T];
   logic signed [CW-1:0] dut_mem  [T];

   function automatic int flat(input int b, input int l, input int i);
      return b * NL * LS + l * LS + i;
   endfunction

   // Synchronous coefficient sources: data appears the cycle after the read.
   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.gold_coef <= gold_mem[flat(int'(bus.rd_bank), int'(bus.rd_lut), int'(bus.rd_idx))];
         bus.dut_coef  <= dut_mem[flat(int'(bus.rd_bank), int'(bus.rd_lut), int'(bus.rd_idx))];
      end
      if (bus2.rd_en) begin
         bus2.gold_coef <= CW'(flat(int'(bus2.rd_bank), int'(bus2.rd_lut), int'(bus2.rd_idx)));
         bus2.dut_coef  <= CW'(flat(int'(bus2.rd_bank), int'(bus2.rd_lut), int'(bus2.rd_idx)) ^ 32'h05A5A5);
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clean_mem(input bit rnd);
      for (int i = 0; i < T; i++) begin
         gold_mem[i] = rnd ? CW'($urandom) : CW'(i);
         dut_mem[i]  = gold_mem[i];
      end
   endtask

   // Pulses start, then watches until done (bounded), tracking read order.
   task automatic run_scan(input int start_again_at, output int done_at,
                           output int rd_cnt, output int addr_bad);
      done_at  = -1;
      rd_cnt   = 0;
      addr_bad = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         start = (k == start_again_at);
         if (bus.rd_en) begin
            if (flat(int'(bus.rd_bank), int'(bus.rd_lut), int'(bus.rd_idx)) != rd_cnt) addr_bad++;
            rd_cnt++;
         end
         if (done) begin
            done_at = k;
            break;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   typedef struct {
      int p0; logic [CW-1:0] got0, exp0;
      int p1; logic [CW-1:0] got1, exp1;
      int e_cnt; bit e_pass; bit e_fev;
      int e_b, e_l, e_i; logic [CW-1:0] e_got, e_exp;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int done_at, rd_cnt, addr_bad, ndone, busy_low, m_cnt, m_first, n, p;
      bit seen;
      logic [CW-1:0] x;

      vecs[0] = '{-1, 0, 0, -1, 0, 0, 0, 1'b1, 1'b0, 0, 0, 0, 0, 0};
      vecs[1] = '{93, 24'h000123, 24'h000124, 120, 24'hFFFFFF, 24'h000078,
                  2, 1'b0, 1'b1, 1, 3, 5, 24'h000123, 24'h000124};
      vecs[2] = '{127, 24'h800000, 24'h00007F, -1, 0, 0,
                  1, 1'b0, 1'b1, 1, 7, 7, 24'h800000, 24'h00007F};
      vecs[3] = '{0, 24'h800000, 24'h000000, -1, 0, 0,
                  1, 1'b0, 1'b1, 0, 0, 0, 24'h800000, 24'h000000};
      vecs[4] = '{64, 24'h000000, 24'h000040, 63, 24'h00003E, 24'h00003F,
                  2, 1'b0, 1'b1, 0, 7, 7, 24'h00003E, 24'h00003F};

      rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
      clean_mem(1'b0);
      repeat (3) @(negedge clk);
      check("reset_rd_en", bus.rd_en, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_pass", pass, 0);
      check("reset_err_cnt", err_cnt, 0);
      check("reset_fev", fev, 0);
      check("reset_addr", {bus.rd_bank, bus.rd_lut, bus.rd_idx}, 0);
      rst = 1'b0;

      for (int v = 0; v < 5; v++) begin
         clean_mem(1'b0);
         if (vecs[v].p0 >= 0) begin gold_mem[vecs[v].p0] = vecs[v].exp0; dut_mem[vecs[v].p0] = vecs[v].got0; end
         if (vecs[v].p1 >= 0) begin gold_mem[vecs[v].p1] = vecs[v].exp1; dut_mem[vecs[v].p1] = vecs[v].got1; end
         run_scan(0, done_at, rd_cnt, addr_bad);
         check($sformatf("vec%0d_done_at", v), done_at, 130);
         check($sformatf("vec%0d_rd_cnt", v), rd_cnt, T);
         check($sformatf("vec%0d_addr_order", v), addr_bad, 0);
         check($sformatf("vec%0d_err_cnt", v), err_cnt, vecs[v].e_cnt);
         check($sformatf("vec%0d_pass", v), pass, vecs[v].e_pass);
         check($sformatf("vec%0d_fev", v), fev, vecs[v].e_fev);
         if (vecs[v].e_fev) begin
            check($sformatf("vec%0d_fe_addr", v), {feb, fel, fei},
                  {vecs[v].e_b[0:0], vecs[v].e_l[2:0], vecs[v].e_i[2:0]});
            check($sformatf("vec%0d_fe_got", v), $unsigned(fegot), vecs[v].e_got);
            check($sformatf("vec%0d_fe_exp", v), $unsigned(feexp), vecs[v].e_exp);
         end
         if (v == 0) begin
            check("sat_done", done2, 1);
            check("sat_err_cnt", err_cnt2, 3);
            check("sat_pass", pass2, 0);
            check("sat_fev", fev2, 1);
            check("sat_fe_addr", {feb2, fel2, fei2}, 0);
            check("sat_fe_got", $unsigned(fegot2), 24'h05A5A5);
            check("sat_fe_exp", $unsigned(feexp2), 0);
         end
      end

      for (int r = 0; r < 6; r++) begin
         clean_mem(1'b1);
         n = $urandom_range(0, 4);
         for (int j = 0; j < n; j++) begin
            p = $urandom_range(0, T - 1);
            x = CW'($urandom_range(1, 32'hFFFFFF));
            dut_mem[p] = gold_mem[p] ^ x;
         end
         m_cnt = 0; m_first = -1;
         for (int i = 0; i < T; i++)
            if (dut_mem[i] != gold_mem[i]) begin
               if (m_first < 0) m_first = i;
               if (m_cnt < 65535) m_cnt++;
            end
         run_scan(0, done_at, rd_cnt, addr_bad);
         check($sformatf("rnd%0d_done_at", r), done_at, 130);
         check($sformatf("rnd%0d_err_cnt", r), err_cnt, m_cnt);
         check($sformatf("rnd%0d_pass", r), pass, m_cnt == 0);
         check($sformatf("rnd%0d_fev", r), fev, m_first >= 0);
         if (m_first >= 0) begin
            check($sformatf("rnd%0d_fe_bank", r), feb, m_first / (NL * LS));
            check($sformatf("rnd%0d_fe_lut", r), fel, (m_first / LS) % NL);
            check($sformatf("rnd%0d_fe_idx", r), fei, m_first % LS);
            check($sformatf("rnd%0d_fe_got", r), $unsigned(fegot), $unsigned(dut_mem[m_first]));
            check($sformatf("rnd%0d_fe_exp", r), $unsigned(feexp), $unsigned(gold_mem[m_first]));
         end
      end

      clean_mem(1'b0);
      continuous = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      ndone = 0; busy_low = 0;
      for (int k = 1; k <= 600; k++) begin
         if (!busy) busy_low++;
         if (done) begin
            check($sformatf("cont_done%0d_at", ndone), k, 130 + 129 * ndone);
            check($sformatf("cont_done%0d_err_cnt", ndone), err_cnt, 0);
            check($sformatf("cont_done%0d_pass", ndone), pass, 1);
            ndone++;
            if (ndone == 3) break;
         end
         @(negedge clk);
      end
      check("cont_done_count", ndone, 3);
      check("cont_busy_low_cycles", busy_low, 0);
      continuous = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; break; end
      end
      check("cont_final_done", seen, 1);
      check("cont_final_busy", busy, 0);

      run_scan(0, done_at, rd_cnt, addr_bad);
      check("pre_abort_pass", pass, 1);
      dut_mem[5] = gold_mem[5] ^ 24'sd1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 1; k < 40; k++) @(negedge clk);
      check("abort_cycle_rd_en", bus.rd_en, 1);
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_rd_en", bus.rd_en, 0);
      check("abort_pass_kept", pass, 1);
      ndone = 0; busy_low = 0;
      for (int k = 0; k < 200; k++) begin
         if (done) ndone++;
         if (busy) busy_low++;
         @(negedge clk);
      end
      check("abort_no_done", ndone, 0);
      check("abort_stays_idle", busy_low, 0);

      clean_mem(1'b0);
      dut_mem[10] = gold_mem[10] ^ 24'sd4;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 1; k < 60; k++) @(negedge clk);
      check("pre_rst_err_cnt", err_cnt, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_rd_en", bus.rd_en, 0);
      check("rst_addr", {bus.rd_bank, bus.rd_lut, bus.rd_idx}, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_fev", fev, 0);
      check("rst_fe_fields", {feb, fel, fei, fegot, feexp}, 0);
      clean_mem(1'b0);
      run_scan(50, done_at, rd_cnt, addr_bad);
      check("post_rst_done_at", done_at, 130);
      check("post_rst_rd_cnt", rd_cnt, T);
      check("post_rst_addr_order", addr_bad, 0);
      check("post_rst_pass", pass, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lut_coef_checker.md
LUT_COEF_CHECKER -- requirements
Module: lut_coef_checker

Interface
REQ-001 SHALL have parameter N_BANKS, default 2, number of coefficient banks (lookahead, lookback).
REQ-002 SHALL have parameter N_LUTS, default 8, LUT slices per bank.
REQ-003 SHALL have parameter LUT_SIZE, default 8, coefficients per LUT slice.
REQ-004 SHALL have parameter COEF_W, default 24, signed coefficient width.
REQ-005 SHALL have parameter CNT_W, default 16, error-counter width.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk, input, 1, clock; rst, input, 1, reset.
REQ-007 SHALL have start, input, 1, scan request pulse.
REQ-008 SHALL have continuous, input, 1, restart scan automatically after done.
REQ-009 SHALL have abort, input, 1, terminate scan.
REQ-010 SHALL have rd_en, output, 1, read strobe to both coefficient sources.
REQ-011 SHALL have rd_bank / rd_lut / rd_idx, output, max(1,clog2(N_BANKS/N_LUTS/LUT_SIZE)), read address.
REQ-012 SHALL have dut_coef and gold_coef, input, COEF_W signed, loaded and golden coefficient.
REQ-013 SHALL have busy, done, pass, output, 1 each: scan active, one-cycle completion pulse, last completed scan had zero mismatches.
REQ-014 SHALL have err_cnt, output, CNT_W, mismatches in current/last scan.
REQ-015 SHALL have first_err_valid, output, 1, plus first_err_bank/lut/idx (address widths) and first_err_got/first_err_exp (COEF_W): first-mismatch capture.

Function
REQ-016 SHALL implement FSM IDLE, SCAN, DRAIN; IDLE->SCAN on start; SCAN->DRAIN after last address; DRAIN->IDLE, or DRAIN->SCAN when continuous=1.
REQ-017 SHALL issue one address per SCAN cycle, order idx fastest, then lut, then bank, starting at (0,0,0); T = N_BANKS*N_LUTS*LUT_SIZE addresses per scan.
REQ-018 SHALL sample dut_coef/gold_coef exactly one cycle after the rd_en cycle carrying their address.
REQ-019 SHALL compare full COEF_W bits; a mismatch increments err_cnt, saturating at 2^CNT_W-1.
REQ-020 SHALL, on the first mismatch of a scan only, latch address, got and expected, and set first_err_valid.
REQ-021 SHALL pulse done one cycle after the last compare: done T+2 cycles after the start cycle; pass updated in the same cycle.
REQ-022 SHALL clear err_cnt and first_err_valid in the cycle a scan begins (start or continuous restart).
REQ-023 SHALL ignore start while busy.
REQ-024 SHALL on abort (any state) drop rd_en next cycle, return to IDLE, discard in-flight compare, not pulse done, leave pass unchanged; abort wins over simultaneous start.
REQ-025 SHALL hold busy high in SCAN and DRAIN, including across a continuous restart (no idle gap).

Reset
REQ-026 SHALL on rst force IDLE and all outputs 0 (rd_en, addresses, busy, done, pass, err_cnt, first_err_*), including mid-scan; rst dominates start and abort.

Structure
REQ-027 SHALL place the state enum and a first-error record struct (bank, lut, idx, got, exp) in shared package lut_check_pkg.
REQ-028 SHALL use one sub-module lut_scan_addr: nested bank/lut/idx counter with clear, enable and last flag.

Verification
REQ-029 Defaults, gold=dut=index pattern, start pulse -> 128 rd_en cycles, done at cycle 130, pass=1, err_cnt=0.
REQ-030 dut differs at bank 1, lut 3, idx 5 (got 0x000123, exp 0x000124) and bank 1, lut 7, idx 0 -> err_cnt=2, pass=0, first_err fields = (1,3,5,0x000123,0x000124).
REQ-031 continuous=1, clean data -> done every 129 cycles, busy never drops, err_cnt=0 each scan.
REQ-032 abort at scan cycle 40 with start in same cycle -> IDLE, no done, busy low next cycle, pass retains prior value.
REQ-033 rst asserted at scan cycle 60 -> all outputs 0 next cycle; subsequent start gives a full 128-address scan.
REQ-034 CNT_W=2, all 128 entries mismatched -> err_cnt saturates at 3, pass=0, first_err_idx=0.
